// File: rtl/m_sd_card_cmd_tx_if.sv
// Command-mux to CMD-line transmitter bus: request, command fields, pad drive and status.
interface m_sd_card_cmd_tx_if;
    logic       Send_CMD_En;
    logic [5:0] CMD_ID;
    logic [7:0] Arg1;
    logic [7:0] Arg2;
    logic [7:0] Arg3;
    logic [7:0] Arg4;
    logic       cmd_out;
    logic       cmd_oe;
    logic       busy;
    logic [6:0] frame_crc;
    logic       Send_CMD_Complite;

    modport master (
        output Send_CMD_En, CMD_ID, Arg1, Arg2, Arg3, Arg4,
        input  cmd_out, cmd_oe, busy, frame_crc, Send_CMD_Complite
    );

    modport slave (
        input  Send_CMD_En, CMD_ID, Arg1, Arg2, Arg3, Arg4,
        output cmd_out, cmd_oe, busy, frame_crc, Send_CMD_Complite
    );
endinterface

// File: rtl/m_sd_card_cmd_tx.sv
// SD CMD-line transmitter: serialises a 48-bit command frame with CRC7, MSB first, one bit per clk.
// Optional macro SD_CMD_TX_ABORT_EN: dropping Send_CMD_En mid-frame aborts the transmission.
module m_sd_card_cmd_tx #(
    parameter int unsigned GAP_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    m_sd_card_cmd_tx_if.slave    bus
);
    localparam int unsigned HDR_W = 40;
    localparam int unsigned CRC_W = 7;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned GAP_W = 4;
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(47);
    localparam logic [IDX_W-1:0] CRC_START = IDX_W'(8);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_bit_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [HDR_W-1:0] r_hdr;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] r_frame_crc;
    logic             r_cmd_out;
    logic             r_cmd_oe;
    logic             r_busy;
    logic             r_complite;

    logic [7:0]       w_tail_vec;
    logic             w_tail_bit;

    // CRC7 bits followed by the end bit, indexed directly by the low bits of the frame index
    assign w_tail_vec = {r_crc, 1'b1};
    assign w_tail_bit = w_tail_vec[r_bit_idx[2:0]];

    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = b ^ c[CRC_W-1];
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_idx   <= '0;
            r_gap_cnt   <= '0;
            r_hdr       <= '0;
            r_crc       <= '0;
            r_frame_crc <= '0;
            r_cmd_out   <= 1'b1;
            r_cmd_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_complite  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_oe  <= 1'b0;
                    r_cmd_out <= 1'b1;
                    if (bus.Send_CMD_En && !r_complite) begin
                        r_hdr     <= {2'b01, bus.CMD_ID, bus.Arg1, bus.Arg2, bus.Arg3, bus.Arg4};
                        r_crc     <= '0;
                        r_bit_idx <= LAST_BIT;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
`ifdef SD_CMD_TX_ABORT_EN
                    if (!bus.Send_CMD_En) begin
                        r_cmd_oe  <= 1'b0;
                        r_cmd_out <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else
`endif
                    begin
                        r_cmd_oe <= 1'b1;
                        if (r_bit_idx >= CRC_START) begin
                            r_cmd_out <= r_hdr[HDR_W-1];
                            r_crc     <= crc7_step(r_crc, r_hdr[HDR_W-1]);
                            r_hdr     <= {r_hdr[HDR_W-2:0], 1'b0};
                        end else begin
                            r_cmd_out <= w_tail_bit;
                        end
                        if (r_bit_idx == '0) begin
                            r_frame_crc <= r_crc;
                            r_gap_cnt   <= '0;
                            r_state     <= S_GAP;
                        end else begin
                            r_bit_idx <= r_bit_idx - IDX_W'(1);
                        end
                    end
                end

                S_GAP: begin
`ifdef SD_CMD_TX_ABORT_EN
                    if (!bus.Send_CMD_En) begin
                        r_cmd_oe  <= 1'b0;
                        r_cmd_out <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else
`endif
                    begin
                        r_cmd_out <= 1'b1;
                        if (r_gap_cnt == GAP_LAST) begin
                            r_cmd_oe   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_complite <= bus.Send_CMD_En;
                            r_state    <= S_DONE;
                        end else begin
                            r_cmd_oe  <= 1'b1;
                            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    r_cmd_oe  <= 1'b0;
                    r_cmd_out <= 1'b1;
                    r_busy    <= 1'b0;
                    // completion stays up until the requester withdraws the request
                    if (bus.Send_CMD_En) begin
                        r_complite <= 1'b1;
                    end else begin
                        r_complite <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_out           = r_cmd_out;
    assign bus.cmd_oe            = r_cmd_oe;
    assign bus.busy              = r_busy;
    assign bus.frame_crc         = r_frame_crc;
    assign bus.Send_CMD_Complite = r_complite;

endmodule

// File: tb/tb_m_sd_card_cmd_tx.sv
// Directed self-checking bench for m_sd_card_cmd_tx (default GAP_BITS=2).
module tb_m_sd_card_cmd_tx;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    m_sd_card_cmd_tx_if u_if();

    m_sd_card_cmd_tx #(.GAP_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7_model(input logic [39:0] hdr);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = hdr[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Starts a frame at the next edge (N) and observes edges N+1..N+51.
    // drop_c>0 lowers Send_CMD_En right after edge N+drop_c.
    task automatic run_frame(input logic [5:0] id, input logic [31:0] arg, input int drop_c,
                             input bit scramble, output logic [47:0] got, output int oe_cnt,
                             output int first_cpl);
        u_if.CMD_ID      = id;
        u_if.Arg1        = arg[31:24];
        u_if.Arg2        = arg[23:16];
        u_if.Arg3        = arg[15:8];
        u_if.Arg4        = arg[7:0];
        u_if.Send_CMD_En = 1'b1;
        tick();
        check("busy_at_latch", 64'(u_if.busy), 64'd1);
        check("oe_at_latch", 64'(u_if.cmd_oe), 64'd0);
        got       = '0;
        oe_cnt    = 0;
        first_cpl = -1;
        for (int c = 1; c <= 51; c++) begin
            if (scramble) begin
                u_if.CMD_ID = 6'($urandom);
                u_if.Arg1   = 8'($urandom);
                u_if.Arg2   = 8'($urandom);
                u_if.Arg3   = 8'($urandom);
                u_if.Arg4   = 8'($urandom);
            end
            tick();
            if (c <= 48) got[48-c] = u_if.cmd_out;
            if (u_if.cmd_oe) oe_cnt++;
            if (u_if.Send_CMD_Complite && first_cpl < 0) first_cpl = c;
            if (c == drop_c) u_if.Send_CMD_En = 1'b0;
        end
    endtask

    logic [47:0] got;
    logic [47:0] exp_frame;
    logic [39:0] hdr;
    logic [6:0]  prev_crc;
    int          oe_cnt;
    int          first_cpl;

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        u_if.Send_CMD_En = 1'b0;
        u_if.CMD_ID      = '0;
        u_if.Arg1        = '0;
        u_if.Arg2        = '0;
        u_if.Arg3        = '0;
        u_if.Arg4        = '0;
        tick();
        tick();
        check("rst_cmd_out", 64'(u_if.cmd_out), 64'd1);
        check("rst_cmd_oe", 64'(u_if.cmd_oe), 64'd0);
        check("rst_busy", 64'(u_if.busy), 64'd0);
        check("rst_crc", 64'(u_if.frame_crc), 64'd0);
        check("rst_cpl", 64'(u_if.Send_CMD_Complite), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_no_start", 64'(u_if.busy), 64'd0);

        // CMD0, arg 0
        run_frame(6'd0, 32'h0000_0000, 0, 1'b0, got, oe_cnt, first_cpl);
        check("cmd0_frame", 64'(got), 64'h40_0000_0000_95);
        check("cmd0_crc", 64'(u_if.frame_crc), 64'h4A);
        check("cmd0_cpl_latency", 64'(first_cpl), 64'd51);
        check("cmd0_oe_cycles", 64'(oe_cnt), 64'd50);
        check("cmd0_busy_done", 64'(u_if.busy), 64'd0);
        u_if.Send_CMD_En = 1'b0;
        tick();
        check("cmd0_cpl_fall", 64'(u_if.Send_CMD_Complite), 64'd0);

        // CMD8, arg 0x1AA; then hold En high to prove no restart while Complite is up
        run_frame(6'd8, 32'h0000_01AA, 0, 1'b0, got, oe_cnt, first_cpl);
        check("cmd8_frame", 64'(got), 64'h48_0000_01AA_87);
        check("cmd8_crc", 64'(u_if.frame_crc), 64'h43);
        check("cmd8_oe_cycles", 64'(oe_cnt), 64'd50);
        check("cmd8_cpl_latency", 64'(first_cpl), 64'd51);
        u_if.CMD_ID = 6'd17;
        u_if.Arg3   = 8'h08;
        u_if.Arg4   = 8'h00;
        tick();
        tick();
        tick();
        check("hold_cpl", 64'(u_if.Send_CMD_Complite), 64'd1);
        check("hold_no_busy", 64'(u_if.busy), 64'd0);
        check("hold_no_oe", 64'(u_if.cmd_oe), 64'd0);
        u_if.Send_CMD_En = 1'b0;
        tick();
        check("cmd8_cpl_fall", 64'(u_if.Send_CMD_Complite), 64'd0);

        // CMD17, arg 0x800, checked against the software CRC model
        hdr       = {2'b01, 6'd17, 32'h0000_0800};
        exp_frame = {hdr, crc7_model(hdr), 1'b1};
        run_frame(6'd17, 32'h0000_0800, 0, 1'b0, got, oe_cnt, first_cpl);
        check("cmd17_frame", 64'(got), 64'(exp_frame));
        check("cmd17_crc", 64'(u_if.frame_crc), 64'(crc7_model(hdr)));
        check("cmd17_cpl_latency", 64'(first_cpl), 64'd51);
        u_if.Send_CMD_En = 1'b0;
        tick();

        // CMD55 interrupted by rst just after bit 20 is driven
        u_if.CMD_ID      = 6'd55;
        u_if.Arg1        = 8'h00;
        u_if.Arg2        = 8'h00;
        u_if.Arg3        = 8'h00;
        u_if.Arg4        = 8'h00;
        u_if.Send_CMD_En = 1'b1;
        tick();
        for (int c = 1; c <= 28; c++) tick();
        check("cmd55_midframe_oe", 64'(u_if.cmd_oe), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst_oe", 64'(u_if.cmd_oe), 64'd0);
        check("midrst_out", 64'(u_if.cmd_out), 64'd1);
        check("midrst_busy", 64'(u_if.busy), 64'd0);
        check("midrst_cpl", 64'(u_if.Send_CMD_Complite), 64'd0);
        check("midrst_crc", 64'(u_if.frame_crc), 64'd0);
        rst = 1'b0;
        run_frame(6'd0, 32'h0000_0000, 0, 1'b0, got, oe_cnt, first_cpl);
        check("post_rst_cmd0_frame", 64'(got), 64'h40_0000_0000_95);
        check("post_rst_cmd0_crc", 64'(u_if.frame_crc), 64'h4A);
        u_if.Send_CMD_En = 1'b0;
        tick();

        // CMD55 with En dropped after bit 10 is driven
        prev_crc = u_if.frame_crc;
        run_frame(6'd55, 32'h0000_0000, 38, 1'b0, got, oe_cnt, first_cpl);
        check("drop_no_cpl", 64'(first_cpl), -64'sd1);
`ifdef SD_CMD_TX_ABORT_EN
        exp_frame = 48'h77_0000_0000_65;
        exp_frame[9:0] = 10'h3FF;
        check("abort_frame", 64'(got), 64'(exp_frame));
        check("abort_oe_cycles", 64'(oe_cnt), 64'd38);
        check("abort_crc_kept", 64'(u_if.frame_crc), 64'(prev_crc));
`else
        check("drop_full_frame", 64'(got), 64'h77_0000_0000_65);
        check("drop_oe_cycles", 64'(oe_cnt), 64'd50);
        check("drop_crc", 64'(u_if.frame_crc), 64'h32);
`endif
        tick();
        check("drop_idle_busy", 64'(u_if.busy), 64'd0);
        check("drop_idle_cpl", 64'(u_if.Send_CMD_Complite), 64'd0);

        // CMD8 with CMD_ID/Arg scrambled every cycle after latch
        run_frame(6'd8, 32'h0000_01AA, 0, 1'b1, got, oe_cnt, first_cpl);
        check("scramble_frame", 64'(got), 64'h48_0000_01AA_87);
        check("scramble_crc", 64'(u_if.frame_crc), 64'h43);
        check("scramble_cpl", 64'(first_cpl), 64'd51);
        u_if.Send_CMD_En = 1'b0;
        tick();
        check("scramble_cpl_fall", 64'(u_if.Send_CMD_Complite), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
